switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Upstream conditioning stage for the board switches. Synchronises N raw slide-switch
//  inputs to clk, debounces each bit independently, and drives the clean vector into the
//  thermometer encoder/decoder. Also emits one-cycle rise/fall pulses per bit for
//  edge-triggered consumers.
// PARAMETERS
//  N              8        number of switch bits (7 data switches + sel)
//  STABLE_CYCLES  1000000  cycles a synced bit must differ from clean before clean follows
//                          (10 ms at 100 MHz); legal range >= 2
//  CNT_W          20       counter width; must satisfy 2**CNT_W >= STABLE_CYCLES
// PORTS
//  clk      in   1   system clock, rising-edge
//  rst_n    in   1   asynchronous active-low reset
//  raw      in   N   unsynchronised switch inputs
//  clean    out  N   debounced switch levels
//  rise     out  N   1-cycle pulse: clean[i] went 0->1 on this edge
//  fall     out  N   1-cycle pulse: clean[i] went 1->0 on this edge
//  changed  out  1   OR-reduction of (rise | fall), registered with them
// BEHAVIOUR
//  Reset (rst_n=0, async assert; deassertion is sampled by clk)
//   - sync stages, counters, clean, rise, fall and changed all go to 0 immediately.
//   - A switch held at 1 through reset produces a normal rise pulse after full latency.
//  Synchroniser
//   - 2-flop chain per bit: s1 <= raw, s2 <= s1. Only s2 is used downstream.
//  Per-bit debounce (identical, independent for every bit i)
//   - If s2[i] == clean[i]: cnt[i] <= 0 and clean holds.
//   - If s2[i] != clean[i] and cnt[i] != STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   - If s2[i] != clean[i] and cnt[i] == STABLE_CYCLES-1: clean[i] <= s2[i], cnt[i] <= 0,
//     rise[i] or fall[i] <= 1 according to the new level.
//   - rise/fall are 0 on every other edge. They never assert together for the same bit.
//  Latency
//   - raw held at a new value from edge t (first edge that samples it into s1):
//     clean flips at edge t+STABLE_CYCLES+1. rise/fall are high for exactly the cycle
//     that follows that edge.
//  Boundary conditions
//   - Bounce: any single cycle with s2==clean restarts the count from 0. A level must
//     persist for a full STABLE_CYCLES run.
//   - Counter never wraps. It is bounded by STABLE_CYCLES-1 and cleared on a match.
//   - Simultaneous bit changes: each bit resolves on its own schedule. Several
//     rise/fall bits may pulse in the same cycle, and changed is asserted once.
//   - Reset mid-count: the count is discarded. After deassertion a full STABLE_CYCLES
//     run is required again.
//   - Raw returning to the old level before expiry: no pulse, clean unchanged.
//  Outputs are registered only. There is no combinational path from raw to any output.
// STRUCTURE
//  - Sub-module debounce_bit: holds s1, s2, cnt, the clean bit and the rise/fall bit for
//    one bit, with parameters STABLE_CYCLES and CNT_W.
//  - The top level instantiates N copies with a generate loop, then registers changed.
//  - Shared package/include: board defaults CLK_HZ=100000000, DEBOUNCE_MS=10, and the
//    derived DEFAULT_STABLE_CYCLES. Board top levels take STABLE_CYCLES from there.
//  - The bench overrides STABLE_CYCLES directly.
// TESTING (bench uses N=8, STABLE_CYCLES=4, CNT_W=3)
//  1 Reset: rst_n=0 asserted mid-cycle with raw=8'hFF -> all outputs 0 without waiting for
//    a clk edge. Release, hold raw=8'hFF -> clean=8'hFF at edge t+5, rise=8'hFF for one
//    cycle, changed=1 for one cycle.
//  2 Clean step: raw[0] 0->1 sampled at edge t -> clean[0]=1 at t+5, rise[0]=1 only in the
//    cycle after t+5. raw[0] 1->0 later gives fall[0] with the same latency.
//  3 Bounce: raw[3] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during the
//    bounce. clean[3] rises exactly 5 edges after the final 0->1 sample.
//  4 Short glitch: raw[5]=1 for 3 cycles, then back to 0 -> clean, rise, fall and changed
//    all stay 0.
//  5 Simultaneous: raw 8'h00->8'h81 on one edge -> clean=8'h81 on a single edge, rise=8'h81
//    for one cycle, changed high for that cycle only.
//  6 Reset mid-count: raw[2]=1, assert rst_n=0 after 2 counting edges, release -> clean[2]
//    stays 0 until a full 5-edge latency measured from the first post-reset sample.
//  Checkers on every cycle:
//   - rise & fall == 0.
//   - changed == |(rise|fall).
//   - clean changes only on a cycle where the matching rise/fall bit pulses.

Source files
------------

// File: rtl/switch_debouncer_pkg.sv
// Board-level debounce defaults shared by the switch conditioning logic and board tops.
package switch_debouncer_pkg;

  localparam int CLK_HZ      = 100000000;
  localparam int DEBOUNCE_MS = 10;

  localparam int DEFAULT_STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Smallest counter width whose range covers 0 .. cycles-1.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((64'(1) << w) < 64'(cycles)) w++;
    return w;
  endfunction

  localparam int DEFAULT_CNT_W = min_cnt_w(DEFAULT_STABLE_CYCLES);

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter and registered edge pulses.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic fire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || CNT_W < min_cnt_w(STABLE_CYCLES)) begin : g_bad_param
    $error("debounce_bit: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic             s1_p0;
  logic             s2_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             differ;

  // Counter is saturation-free by construction: it is cleared on the terminal count.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    return (c == LAST) ? '0 : c + 1'b1;
  endfunction

  assign differ = (s2_p1 != clean);
  assign fire   = differ && (cnt_p2 == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0  <= 1'b0;
      s2_p1  <= 1'b0;
      cnt_p2 <= '0;
      clean  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // p0/p1: metastability chain
      s1_p0 <= raw;
      s2_p1 <= s1_p0;
      // p2: any cycle agreeing with clean restarts the stability run
      cnt_p2 <= differ ? bump(cnt_p2) : '0;
      if (fire) clean <= s2_p1;
      rise <= fire & s2_p1;
      fall <= fire & ~s2_p1;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// N-bit switch conditioner: independent per-bit debounce plus a shared change strobe.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int N             = 8,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  logic [N-1:0] fire;

  for (genvar i = 0; i < N; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .clean(clean[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .fire (fire[i])
    );
  end

  // Registered from the same terms that load rise/fall, so it lines up with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |fire;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and randomized bench for switch_debouncer against a history-window reference model.
module tb_switch_debouncer;

  localparam int N    = 8;
  localparam int S    = 4;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw;
  logic [N-1:0] clean, rise, fall;
  logic         changed;

  int total  = 0;
  int passed = 0;

  switch_debouncer #(.N(N), .STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (raw),
    .clean  (clean),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: every sampled raw vector is kept by edge index. A bit's clean level
  // flips on edge e when the synced value (raw from two edges earlier, 0 right after reset)
  // disagreed with clean on each of the last S edges since the bit's last flip or reset.
  logic [N-1:0] raw_hist [HMAX];
  int           ecount = 0;
  int           e0     = 0;
  int           start [N] = '{default: 0};
  logic [N-1:0] m_clean = '0, m_rise = '0, m_fall = '0;
  logic         m_chg = 1'b0;

  function automatic logic sync_at(input int k, input int b);
    if (k - 2 >= e0) return raw_hist[k-2][b];
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] flips(input int e);
    logic [N-1:0] f;
    f = '1;
    for (int b = 0; b < N; b++)
      for (int j = 0; j < S; j++)
        if (e - j < start[b] || sync_at(e - j, b) == m_clean[b]) f[b] = 1'b0;
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clean <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_chg   <= 1'b0;
      e0      <= ecount;
      for (int b = 0; b < N; b++) start[b] <= ecount;
    end else begin
      raw_hist[ecount] <= raw;
      m_clean <= m_clean ^ flips(ecount);
      m_rise  <= flips(ecount) & ~m_clean;
      m_fall  <= flips(ecount) & m_clean;
      m_chg   <= |flips(ecount);
      for (int b = 0; b < N; b++)
        if (flips(ecount)[b]) start[b] <= ecount + 1;
      ecount <= ecount + 1;
    end
  end

  logic [N-1:0] prev_clean = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Advance n clock cycles, checking every cycle on the falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("model_clean", 32'(clean), 32'(m_clean));
      chk("model_rise", 32'(rise), 32'(m_rise));
      chk("model_fall", 32'(fall), 32'(m_fall));
      chk("model_changed", 32'(changed), 32'(m_chg));
      chk("rise_and_fall", 32'(rise & fall), 32'd0);
      chk("changed_is_or", 32'(changed), 32'(|(rise | fall)));
      chk("clean_without_pulse", 32'((clean ^ prev_clean) & ~(rise | fall)), 32'd0);
      prev_clean = clean;
    end
  endtask

  // Asynchronous reset asserted between clock edges, released on the next falling edge.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_clean0"}, 32'(clean), 32'd0);
    chk({tag, "_rise0"}, 32'(rise), 32'd0);
    chk({tag, "_fall0"}, 32'(fall), 32'd0);
    chk({tag, "_changed0"}, 32'(changed), 32'd0);
    prev_clean = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // Reset with switches held high, then a full-latency rise on release
    raw = 8'hFF;
    cyc(5);
    chk("pre_reset_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("pre_reset_clean", 32'(clean), 32'hFF);
    mid_reset("t1");
    cyc(5);
    chk("t1_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("t1_clean", 32'(clean), 32'hFF);
    chk("t1_rise", 32'(rise), 32'hFF);
    chk("t1_changed", 32'(changed), 32'd1);
    cyc(1);
    chk("t1_rise_end", 32'(rise), 32'h00);
    chk("t1_changed_end", 32'(changed), 32'd0);

    // Clean single-bit step up and down
    raw = 8'h00;
    cyc(8);
    raw = 8'h01;
    cyc(5);
    chk("t2_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("t2_clean_up", 32'(clean), 32'h01);
    chk("t2_rise", 32'(rise), 32'h01);
    chk("t2_fall_quiet", 32'(fall), 32'h00);
    cyc(1);
    chk("t2_rise_end", 32'(rise), 32'h00);
    cyc(3);
    raw = 8'h00;
    cyc(5);
    chk("t2_clean_hold", 32'(clean), 32'h01);
    cyc(1);
    chk("t2_clean_down", 32'(clean), 32'h00);
    chk("t2_fall", 32'(fall), 32'h01);
    cyc(1);
    chk("t2_fall_end", 32'(fall), 32'h00);

    // Bounce on bit 3 before it settles high
    for (int k = 0; k < 2; k++) begin
      raw = 8'h08;
      cyc(2);
      raw = 8'h00;
      cyc(2);
    end
    raw = 8'h08;
    cyc(5);
    chk("t3_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("t3_clean", 32'(clean), 32'h08);
    chk("t3_rise", 32'(rise), 32'h08);
    raw = 8'h00;
    cyc(8);

    // Glitch one cycle shorter than the stability window
    raw = 8'h20;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("t4_clean", 32'(clean), 32'h00);
      chk("t4_changed", 32'(changed), 32'd0);
    end
    raw = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("t4_clean", 32'(clean), 32'h00);
      chk("t4_pulses", 32'(rise | fall), 32'h00);
      chk("t4_changed", 32'(changed), 32'd0);
    end

    // Two bits changing on the same edge
    raw = 8'h81;
    cyc(5);
    chk("t5_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("t5_clean", 32'(clean), 32'h81);
    chk("t5_rise", 32'(rise), 32'h81);
    chk("t5_changed", 32'(changed), 32'd1);
    cyc(1);
    chk("t5_rise_end", 32'(rise), 32'h00);
    chk("t5_changed_end", 32'(changed), 32'd0);

    // Reset part-way through a count discards it
    raw = 8'h00;
    cyc(8);
    raw = 8'h04;
    cyc(4);
    mid_reset("t6");
    cyc(5);
    chk("t6_clean_early", 32'(clean), 32'h00);
    cyc(1);
    chk("t6_clean", 32'(clean), 32'h04);
    chk("t6_rise", 32'(rise), 32'h04);

    // Randomized hold lengths straddling the stability window
    for (int r = 0; r < 80; r++) begin
      raw = raw ^ (8'($urandom) & 8'($urandom));
      cyc(int'($urandom_range(1, 7)));
    end
    raw = 8'h00;
    cyc(10);
    chk("final_clean", 32'(clean), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
